// File: rtl/clock_step_ctrl_pkg.sv
// Shared encodings and defaults for the front-panel clock controller.
// The FSM state encodings are fixed so that panel debug probes can decode them.
package clock_step_ctrl_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_CNT_W           = 5;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// One panel button: two-flop synchronizer, stable-level debounce counter and
// a rising-edge detector that yields a single-cycle press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic stable,
    output logic press
);

    logic             s1;
    logic             s2;
    logic             stable_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            s1       <= btn_in;
            s2       <= s1;
            stable_q <= stable;
            // Any single cycle of agreement with the accepted level restarts the count.
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press = stable & ~stable_q;

endmodule

// File: rtl/clock_step_ctrl.sv
// Front-panel RUN/STEP control: debounces both buttons and runs the
// HALTED/RUN/STEP machine that gates the CPU clock enable.
module clock_step_ctrl
    import clock_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_run,
    input  logic btn_step,
    input  logic halt_req,
    output logic cpu_clk_en,
    output logic running
);

    localparam int NUM_BTN  = 2;
    localparam int BTN_RUN  = 0;
    localparam int BTN_STEP = 1;

    logic [NUM_BTN-1:0] btn;
    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] press;
    logic               unused_stable;
    logic               run_press;
    logic               step_press;

    assign btn = {btn_step, btn_run};

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_db (
                .clk    (clk),
                .rst    (rst),
                .btn_in (btn[g]),
                .stable (stable[g]),
                .press  (press[g])
            );
        end
    endgenerate

    // Only the press edges drive the FSM; the levels are kept for probing.
    assign unused_stable = ^stable;
    assign run_press     = press[BTN_RUN];
    assign step_press    = press[BTN_STEP];

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_HALTED;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = ST_HALTED;
        cpu_clk_en = 1'b0;
        running    = 1'b0;
        case (state)
            ST_HALTED: begin
                if (run_press)       state_nxt = ST_RUN;
                else if (step_press) state_nxt = ST_STEP;
                else                 state_nxt = ST_HALTED;
            end
            ST_RUN: begin
                // halt_req masks the enable on the same edge the CPU decodes HLT.
                cpu_clk_en = ~halt_req;
                running    = 1'b1;
                state_nxt  = (run_press | halt_req) ? ST_HALTED : ST_RUN;
            end
            ST_STEP: begin
                cpu_clk_en = 1'b1;
                state_nxt  = ST_HALTED;
            end
            default: state_nxt = ST_HALTED;
        endcase
    end

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Bench for clock_step_ctrl with DEBOUNCE_CYCLES=4: a press held from cycle 0
// shows its new state in cycle 7 (state change on edge 6).
module tb_clock_step_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn_run;
    logic btn_step;
    logic halt_req;
    logic cpu_clk_en;
    logic running;

    int checks = 0;
    int errors = 0;

    logic [1:0] sb_q[$];

    typedef struct {
        logic r;
        logic s;
        logic h;
        int   n;
        logic en;
        logic run;
    } vec_t;

    vec_t tbl[$];

    clock_step_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_run    (btn_run),
        .btn_step   (btn_step),
        .halt_req   (halt_req),
        .cpu_clk_en (cpu_clk_en),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, s, h, input int n, input logic en, run);
        vec_t v;
        v.r = r; v.s = s; v.h = h; v.n = n; v.en = en; v.run = run;
        tbl.push_back(v);
    endtask

    task automatic chk_now(input logic ee, er, input string tag);
        checks++;
        if ({cpu_clk_en, running} !== {ee, er}) begin
            errors++;
            $display("FAIL %s: got en=%0b running=%0b, want en=%0b running=%0b",
                     tag, cpu_clk_en, running, ee, er);
        end
    endtask

    // One cycle: drive after the falling edge, push the expectation, then
    // pop and compare 1 time unit later (well clear of the next rising edge).
    task automatic cyc(input logic r, s, h, input logic ee, er, input string tag);
        logic [1:0] exp_v;
        @(negedge clk);
        btn_run  = r;
        btn_step = s;
        halt_req = h;
        sb_q.push_back({ee, er});
        #1;
        exp_v = sb_q.pop_front();
        checks++;
        if ({cpu_clk_en, running} !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0t: got en=%0b running=%0b, want en=%0b running=%0b",
                     tag, $time, cpu_clk_en, running, exp_v[1], exp_v[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; halt_req = 1'b0;
        @(negedge clk);
        #1 chk_now(1'b0, 1'b0, "reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Table: idle, single steps with hold and repress, run toggle with
        // ignored steps, HLT with step while halt_req held, simultaneous press.
        add(0,0,0, 3,0,0);
        add(0,1,0, 7,0,0); add(0,1,0, 1,1,0); add(0,1,0,20,0,0);
        add(0,0,0,10,0,0);
        add(0,1,0, 7,0,0); add(0,1,0, 1,1,0); add(0,1,0, 5,0,0); add(0,0,0, 8,0,0);
        add(1,0,0, 7,0,0); add(1,0,0, 5,1,1); add(0,0,0, 8,1,1);
        add(0,1,0,12,1,1); add(0,0,0, 8,1,1);
        add(1,0,0, 7,1,1); add(1,0,0, 3,0,0); add(0,0,0, 8,0,0);
        add(1,0,0, 7,0,0); add(1,0,0, 3,1,1); add(0,0,0, 8,1,1);
        add(0,0,1, 1,0,1); add(0,0,1, 3,0,0);
        add(0,1,1, 7,0,0); add(0,1,1, 1,1,0); add(0,1,1, 6,0,0); add(0,0,1, 8,0,0);
        add(0,0,0, 2,0,0);
        add(1,1,0, 7,0,0); add(1,1,0, 5,1,1); add(0,0,0, 8,1,1);
        add(1,0,0, 7,1,1); add(1,0,0, 3,0,0); add(0,0,0, 8,0,0);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++)
                cyc(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].en, tbl[i].run,
                    $sformatf("vec%0d.%0d", i, k));
        end

        // Reset mid-RUN, asserted between edges.
        for (int k = 0; k < 7; k++) cyc(1,0,0, 0,0, "rst_enter_wait");
        for (int k = 0; k < 3; k++) cyc(1,0,0, 1,1, "rst_enter_run");
        for (int k = 0; k < 8; k++) cyc(0,0,0, 1,1, "rst_in_run");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_now(1'b0, 1'b0, "rst_async_drop");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) cyc(0,0,0, 0,0, "rst_stays_halted");

        // Button held through reset is re-debounced from scratch.
        @(negedge clk);
        btn_run = 1'b1;
        #2 rst = 1'b1;
        #1 chk_now(1'b0, 1'b0, "rst_held_drop");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) cyc(1,0,0, 0,0, "rst_held_wait");
        for (int k = 0; k < 3; k++) cyc(1,0,0, 1,1, "rst_held_run");
        for (int k = 0; k < 8; k++) cyc(0,0,0, 1,1, "rst_held_rel");
        for (int k = 0; k < 7; k++) cyc(1,0,0, 1,1, "rst_stop_wait");
        for (int k = 0; k < 3; k++) cyc(1,0,0, 0,0, "rst_stop");
        for (int k = 0; k < 8; k++) cyc(0,0,0, 0,0, "rst_stop_rel");

        // Bounce: toggles every 2 cycles for 20 cycles, then a clean hold.
        for (int k = 0; k < 20; k++) cyc(0, ((k / 2) % 2) == 0, 0, 0,0, "bounce");
        for (int k = 0; k < 7; k++)  cyc(0,1,0, 0,0, "bounce_wait");
        cyc(0,1,0, 1,0, "bounce_pulse");
        for (int k = 0; k < 10; k++) cyc(0,1,0, 0,0, "bounce_hold");
        for (int k = 0; k < 10; k++) cyc(0,0,0, 0,0, "bounce_rel");

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
